// File: rtl/clockworks_pkg.sv
// Shared defaults for the clock gearbox / reset generator.
`timescale 1ns/1ps
package clockworks_pkg;

    // Board build: undivided clock, 2^16-cycle reset stretch.
    localparam int DEFAULT_SLOW       = 0;
    localparam int DEFAULT_RESET_BITS = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchronizer whose flops take INIT at FPGA configuration.
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic s1 = INIT;
    logic s2 = INIT;

    always_ff @(posedge clk) begin
        s1 <= d;
        s2 <= s1;
    end

    assign q = s2;

endmodule

// File: rtl/clockworks.sv
// Clock gearbox and stretched power-on/button reset generator for the SoC.
// Power-up state comes solely from register initial values; there is no other reset source.
`timescale 1ns/1ps
module clockworks
    import clockworks_pkg::*;
#(
    parameter int SLOW       = DEFAULT_SLOW,
    parameter int RESET_BITS = DEFAULT_RESET_BITS
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    localparam logic [RESET_BITS-1:0] HOLD_MAX = '1;

    generate
        if (SLOW == 0) begin : g_bypass
            assign clk = CLK;
        end else begin : g_div
            // Free-running, never reset, so clk keeps ticking through button resets.
            logic [SLOW-1:0] div = '0;

            always_ff @(posedge CLK) begin
                div <= div + SLOW'(1);
            end

            assign clk = div[SLOW-1];
        end
    endgenerate

    logic rst_sync;

    sync_2ff #(
        .INIT (1'b0)
    ) u_rst_sync (
        .clk (clk),
        .d   (RESET),
        .q   (rst_sync)
    );

    logic [RESET_BITS-1:0] cnt      = '0;
    logic                  resetn_q = 1'b0;

    // A synchronized request always wins, including on the terminal count edge.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            cnt      <= '0;
            resetn_q <= 1'b0;
        end else if (!resetn_q) begin
            cnt <= cnt + RESET_BITS'(1);
            if (cnt == HOLD_MAX) begin
                resetn_q <= 1'b1;
            end
        end
    end

    assign resetn = resetn_q;

endmodule

// File: tb/tb_clockworks.sv
// Self-checking bench for clockworks: undivided, divided and held-in-reset instances.
`timescale 1ns/1ps
module tb_clockworks;

    logic CLK     = 1'b0;
    logic m_reset = 1'b0;
    logic s_reset = 1'b0;
    logic h_reset = 1'b1;

    logic m_clk, m_resetn;
    logic s_clk, s_resetn;
    logic h_clk, h_resetn;

    int checks    = 0;
    int errors    = 0;
    int clk_edges = 0;

    logic exp_q[$];
    logic exp;

    // Clock / edge counter
    always #5 CLK = ~CLK;

    always @(posedge CLK) clk_edges <= clk_edges + 1;

    clockworks #(.SLOW(0), .RESET_BITS(4)) u_main (
        .CLK    (CLK),
        .RESET  (m_reset),
        .clk    (m_clk),
        .resetn (m_resetn)
    );

    clockworks #(.SLOW(3), .RESET_BITS(4)) u_slow (
        .CLK    (CLK),
        .RESET  (s_reset),
        .clk    (s_clk),
        .resetn (s_resetn)
    );

    clockworks #(.SLOW(0), .RESET_BITS(4)) u_held (
        .CLK    (CLK),
        .RESET  (h_reset),
        .clk    (h_clk),
        .resetn (h_resetn)
    );

    task automatic test_reset();
        #1;
        checks++;
        if (m_resetn !== 1'b0) begin
            errors++;
            $display("FAIL reset_main_resetn: got %b want 0", m_resetn);
        end
        checks++;
        if (s_resetn !== 1'b0) begin
            errors++;
            $display("FAIL reset_slow_resetn: got %b want 0", s_resetn);
        end
        checks++;
        if (h_resetn !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_resetn: got %b want 0", h_resetn);
        end
        checks++;
        if (s_clk !== 1'b0) begin
            errors++;
            $display("FAIL reset_slow_clk: got %b want 0", s_clk);
        end
    endtask

    // resetn low for edges 1..15, high from edge 16; clk mirrors CLK.
    task automatic test_power_up();
        for (int e = 1; e <= 20; e++) begin
            exp_q.push_back(e >= 16);
            @(posedge CLK); #1;
            exp = exp_q.pop_front();
            checks++;
            if (m_resetn !== exp) begin
                errors++;
                $display("FAIL power_up edge %0d: got resetn %b want %b", e, m_resetn, exp);
            end
            checks++;
            if (h_resetn !== 1'b0) begin
                errors++;
                $display("FAIL held_power_up edge %0d: got resetn %b want 0", e, h_resetn);
            end
            checks++;
            if (m_clk !== CLK) begin
                errors++;
                $display("FAIL clk_bypass edge %0d: got clk %b want %b", e, m_clk, CLK);
            end
        end
    endtask

    // SLOW=3: clk = bit 2 of the CLK edge count; resetn rises on the 16th slow edge (CLK edge 124).
    task automatic test_slow();
        for (int i = 0; i < 24; i++) begin
            @(posedge CLK); #1;
            exp_q.push_back(((clk_edges >> 2) & 1) == 1);
            exp = exp_q.pop_front();
            checks++;
            if (s_clk !== exp) begin
                errors++;
                $display("FAIL slow_clk edge %0d: got %b want %b", clk_edges, s_clk, exp);
            end
            #4;
            checks++;
            if (s_clk !== exp) begin
                errors++;
                $display("FAIL slow_clk_mid edge %0d: got %b want %b", clk_edges, s_clk, exp);
            end
        end
        while (clk_edges < 123) begin
            @(posedge CLK); #1;
        end
        checks++;
        if (s_resetn !== 1'b0) begin
            errors++;
            $display("FAIL slow_resetn_early: got %b want 0", s_resetn);
        end
        @(posedge CLK); #1;
        checks++;
        if (s_resetn !== 1'b1) begin
            errors++;
            $display("FAIL slow_resetn_rise: got %b want 1", s_resetn);
        end
        checks++;
        if (m_resetn !== 1'b1) begin
            errors++;
            $display("FAIL main_idle_resetn: got %b want 1", m_resetn);
        end
    endtask

    // RESET high for 5 edges: fall at edge 3, rise 2+16 edges after release (edge 23).
    task automatic test_assert_release();
        m_reset = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            exp_q.push_back(e < 3 || e >= 23);
            @(posedge CLK); #1;
            exp = exp_q.pop_front();
            checks++;
            if (m_resetn !== exp) begin
                errors++;
                $display("FAIL assert_release edge %0d: got resetn %b want %b", e, m_resetn, exp);
            end
            m_reset = (e < 5);
        end
    endtask

    // Second pulse lands when cnt=10; full hold restarts, so rise at edge 34 instead of 20.
    task automatic test_mid_hold();
        m_reset = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            exp_q.push_back(e <= 2 || e >= 34);
            @(posedge CLK); #1;
            exp = exp_q.pop_front();
            checks++;
            if (m_resetn !== exp) begin
                errors++;
                $display("FAIL mid_hold edge %0d: got resetn %b want %b", e, m_resetn, exp);
            end
            m_reset = (e < 2) || (e == 14) || (e == 15);
        end
    endtask

    // rst_sync high on the very edge cnt==15: reset wins, rise deferred to edge 37.
    task automatic test_simultaneous();
        m_reset = 1'b1;
        for (int e = 1; e <= 39; e++) begin
            exp_q.push_back(e <= 2 || e >= 37);
            @(posedge CLK); #1;
            exp = exp_q.pop_front();
            checks++;
            if (m_resetn !== exp) begin
                errors++;
                $display("FAIL simultaneous edge %0d: got resetn %b want %b", e, m_resetn, exp);
            end
            m_reset = (e < 2) || (e == 17) || (e == 18);
        end
    endtask

    task automatic test_held();
        for (int e = 1; e <= 100; e++) begin
            exp_q.push_back(1'b0);
            @(posedge CLK); #1;
            exp = exp_q.pop_front();
            checks++;
            if (h_resetn !== exp) begin
                errors++;
                $display("FAIL held edge %0d: got resetn %b want %b", e, h_resetn, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_slow();
        test_assert_release();
        test_mid_hold();
        test_simultaneous();
        test_held();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
